bcd2_to_bin_seq: RTL and testbench

- Sequential decoder for the 2-digit BCD adder result format: hundreds carry bit, tens digit, ones digit, value range 0..199.
- Converts the 3-field BCD value back to an 8-bit unsigned binary value.
- Uses reverse double-dabble: shift right, then subtract 3 from any BCD digit that is 8 or more.
- Sits downstream of the BCD adder. Feeds binary consumers such as comparators and counters through a start/done handshake.

---
 rtl/bcd2_to_bin_seq.sv | 98 +++++++++
 tb/tb_bcd2_to_bin_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bcd2_to_bin_seq.sv
// Sequential BCD (hundreds bit, tens, ones) to 8-bit binary converter.
// Uses reverse double-dabble: eight right shifts, each followed by a -3 fix on digits >= 8.
module bcd2_to_bin_seq #(
    parameter bit CHECK_VALID = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hund,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    output logic       busy,
    output logic       done,
    output logic [7:0] bin,
    output logic       err
);

    // state  | meaning
    // IDLE   | waiting for start
    // SHIFT  | eight shift/correct iterations in progress
    // REJECT | invalid digits seen, one cycle before the error done pulse
    // DONE   | done pulse cycle, bin/err valid, start may be accepted
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REJECT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [16:0] work;
    logic [2:0]  cnt;

    logic        invalid;
    logic        accept;
    logic [16:0] shifted;
    logic [16:0] corrected;

    assign invalid = CHECK_VALID && ((tens > 4'd9) || (ones > 4'd9));
    assign accept  = start && ((state == IDLE) || (state == DONE));

    always_comb begin
        shifted   = {1'b0, work[16:1]};
        corrected = shifted;
        if (shifted[15:12] >= 4'd8)
            corrected[15:12] = shifted[15:12] - 4'd3;
        if (shifted[11:8] >= 4'd8)
            corrected[11:8] = shifted[11:8] - 4'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bin   <= '0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                work <= {hund, tens, ones, 8'b0};
                cnt  <= '0;
                err  <= 1'b0;
                if (invalid) begin
                    state <= REJECT;
                    busy  <= 1'b0;
                end else begin
                    state <= SHIFT;
                    busy  <= 1'b1;
                end
            end else begin
                case (state)
                    SHIFT: begin
                        work <= corrected;
                        cnt  <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            bin   <= corrected[7:0];
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    REJECT: begin
                        bin   <= '0;
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd2_to_bin_seq.sv
// Directed bench for bcd2_to_bin_seq: latency, busy window, error path, ignored starts,
// continuous start, and mid-conversion reset.
module tb_bcd2_to_bin_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;
    logic       done;
    logic [7:0] bin;
    logic       err;

    int total = 0;
    int bad   = 0;

    bcd2_to_bin_seq #(.CHECK_VALID(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .hund  (hund),
        .tens  (tens),
        .ones  (ones),
        .busy  (busy),
        .done  (done),
        .bin   (bin),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one request, then follow it to done with a bounded wait.
    task automatic run(input logic h, input logic [3:0] t, input logic [3:0] o,
                       input logic [7:0] exp_bin, input logic exp_err,
                       input int exp_lat, input int exp_busy, input string tag);
        int edges;
        int busy_cnt;
        hund  = h;
        tens  = t;
        ones  = o;
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 20) begin
            step();
            edges++;
            if (busy) busy_cnt++;
        end
        check({tag, "_latency"}, edges, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        check({tag, "_bin"}, bin, exp_bin);
        check({tag, "_err"}, err, exp_err);
        step();
        check({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    initial begin
        int edges;
        int pulses;
        int nodone;
        reset = 1'b1;
        start = 1'b0;
        hund  = 1'b0;
        tens  = 4'd0;
        ones  = 4'd0;
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bin", bin, 8'h00);
        check("rst_err", err, 1'b0);
        reset = 1'b0;
        step();

        run(1'b1, 4'd9, 4'd9, 8'hC7, 1'b0, 9, 8, "c199");
        run(1'b0, 4'd0, 4'd0, 8'h00, 1'b0, 9, 8, "c000");
        run(1'b0, 4'd5, 4'd7, 8'h39, 1'b0, 9, 8, "c057");
        run(1'b1, 4'd0, 4'd0, 8'h64, 1'b0, 9, 8, "c100");
        run(1'b0, 4'hA, 4'd3, 8'h00, 1'b1, 2, 0, "inval_tens");
        run(1'b0, 4'd4, 4'd2, 8'h2A, 1'b0, 9, 8, "c042");
        run(1'b0, 4'd1, 4'hF, 8'h00, 1'b1, 2, 0, "inval_ones");

        // Re-pulse start with 0/0/0 during shift cycles 3 and 5, then scramble inputs.
        hund = 1'b1; tens = 4'd9; ones = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        edges = 1;
        while (!done && edges < 20) begin
            if (edges == 3 || edges == 5) begin
                hund = 1'b0; tens = 4'd0; ones = 4'd0; start = 1'b1;
            end else if (edges == 6) begin
                tens = 4'd3; ones = 4'd1; start = 1'b0;
            end else begin
                start = 1'b0;
            end
            step();
            edges++;
        end
        start = 1'b0;
        check("ignore_latency", edges, 9);
        check("ignore_bin", bin, 8'hC7);
        check("ignore_err", err, 1'b0);
        step();
        check("ignore_done_drop", done, 1'b0);
        step();

        // Start held high: a conversion completes every 9 edges.
        hund = 1'b0; tens = 4'd1; ones = 4'd2; start = 1'b1;
        hund = 1'b1; tens = 4'd2; ones = 4'd3;
        pulses = 0;
        for (int i = 1; i <= 27; i++) begin
            step();
            if (done) begin
                pulses++;
                check($sformatf("held_edge_%0d", i), i, pulses * 9);
                check($sformatf("held_bin_%0d", pulses), bin, 8'h7B);
            end
        end
        check("held_pulses", pulses, 3);
        step();
        check("held_busy_again", busy, 1'b1);
        start = 1'b0;
        edges = 0;
        while (!done && edges < 20) begin
            step();
            edges++;
        end
        check("held_tail_bin", bin, 8'h7B);
        step();
        step();

        // Reset at shift iteration 4 aborts without a done pulse.
        hund = 1'b1; tens = 4'd9; ones = 4'd9; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        step();
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_bin", bin, 8'h00);
        check("abort_err", err, 1'b0);
        reset = 1'b0;
        nodone = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done || busy) nodone++;
        end
        check("abort_no_done", nodone, 0);
        run(1'b0, 4'd8, 4'd8, 8'h58, 1'b0, 9, 8, "c088");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
